// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing and the shared coordinate type for the VGA path.
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int COORD_W     = 10;
  localparam int COORD_LIMIT = 1 << COORD_W;

  typedef logic [COORD_W-1:0] pixel_coord_t;

  function automatic pixel_coord_t to_coord(input int value);
    return pixel_coord_t'(value);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: terminal-count counter plus sync/visible decode of the NEXT count,
// so the parent can register the decodes in the same edge that loads the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FP      = DEF_H_FP,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BP      = DEF_H_BP
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  output logic [9:0] o_count,
  output logic [9:0] o_next,
  output logic       o_wrap,
  output logic       o_sync_n_next,
  output logic       o_visible_next
);

  localparam int TOTAL      = VISIBLE + FP + SYNC + BP;
  localparam int SYNC_START = VISIBLE + FP;
  localparam int SYNC_END   = VISIBLE + FP + SYNC;
  localparam pixel_coord_t C_LAST = to_coord(TOTAL - 1);

  if (TOTAL > COORD_LIMIT) begin : g_total_too_large
    $error("vga_axis_counter: axis total %0d exceeds %0d", TOTAL, COORD_LIMIT);
  end

  pixel_coord_t r_count;
  pixel_coord_t w_next;
  logic         w_wrap;
  logic [31:0]  w_next_ext;

  assign w_wrap = i_en && (r_count == C_LAST);

  always_comb begin
    w_next = r_count;
    if (i_en) begin
      w_next = w_wrap ? '0 : r_count + pixel_coord_t'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  // Widen once so the decodes compare against the integer timing parameters cleanly.
  assign w_next_ext = 32'(w_next);

  assign o_count        = r_count;
  assign o_next         = w_next;
  assign o_wrap         = w_wrap;
  assign o_sync_n_next  = !((w_next_ext >= SYNC_START) && (w_next_ext < SYNC_END));
  assign o_visible_next = (w_next_ext < VISIBLE);

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running 640x480@60 raster source: DrawX/DrawY, blank, hs/vs and frame/vblank strobes, all registered.
// Optional completed-frame counter is built only when VGA_TIMING_FRAME_COUNT_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic        vblank_start,
  output logic [15:0] frame_count
);

  localparam pixel_coord_t C_V_VIS = to_coord(V_VISIBLE);

  logic [9:0] w_h_count;
  logic [9:0] w_h_next;
  logic       w_h_wrap;
  logic       w_hs_n_next;
  logic       w_h_vis_next;
  logic [9:0] w_v_count;
  logic [9:0] w_v_next;
  logic       w_v_wrap;
  logic       w_vs_n_next;
  logic       w_v_vis_next;

  logic r_blank;
  logic r_hs;
  logic r_vs;
  logic r_frame_start;
  logic r_vblank_start;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP)
  ) u_h_axis (
    .i_clk          (vga_clk),
    .i_rst          (reset),
    .i_en           (1'b1),
    .o_count        (w_h_count),
    .o_next         (w_h_next),
    .o_wrap         (w_h_wrap),
    .o_sync_n_next  (w_hs_n_next),
    .o_visible_next (w_h_vis_next)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP)
  ) u_v_axis (
    .i_clk          (vga_clk),
    .i_rst          (reset),
    .i_en           (w_h_wrap),
    .o_count        (w_v_count),
    .o_next         (w_v_next),
    .o_wrap         (w_v_wrap),
    .o_sync_n_next  (w_vs_n_next),
    .o_visible_next (w_v_vis_next)
  );

  // Registering next-value decodes keeps every output on the same edge as DrawX/DrawY.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_blank        <= 1'b0;
      r_hs           <= 1'b1;
      r_vs           <= 1'b1;
      r_frame_start  <= 1'b0;
      r_vblank_start <= 1'b0;
    end else begin
      r_blank        <= w_h_vis_next && w_v_vis_next;
      r_hs           <= w_hs_n_next;
      r_vs           <= w_vs_n_next;
      r_frame_start  <= w_v_wrap;
      r_vblank_start <= (w_h_next == '0) && (w_v_next == C_V_VIS);
    end
  end

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_frame_count <= 16'h0;
    end else if (w_v_wrap) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
`else
  assign frame_count = 16'h0;
`endif

  assign DrawX        = w_h_count;
  assign DrawY        = w_v_count;
  assign blank        = r_blank;
  assign hs           = r_hs;
  assign vs           = r_vs;
  assign frame_start  = r_frame_start;
  assign vblank_start = r_vblank_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance for line-level timing, plus a
// reduced-timing instance (32x20 totals) so whole-frame behaviour fits a short run.
module tb_vga_timing_gen;

  logic clk;
  logic rst_a;
  logic rst_b;

  logic [9:0]  x_a, y_a, x_b, y_b;
  logic        blank_a, hs_a, vs_a, fs_a, vb_a;
  logic        blank_b, hs_b, vs_b, fs_b, vb_b;
  logic [15:0] fc_a, fc_b;

  int checks;
  int failures;
  int cyc;

  vga_timing_gen u_dut (
    .vga_clk      (clk),
    .reset        (rst_a),
    .DrawX        (x_a),
    .DrawY        (y_a),
    .blank        (blank_a),
    .hs           (hs_a),
    .vs           (vs_a),
    .frame_start  (fs_a),
    .vblank_start (vb_a),
    .frame_count  (fc_a)
  );

  // Small raster: H 16/4/6/6 (hs low at X 20..25), V 12/3/2/3 (vs low at Y 15..16), 640 clocks/frame.
  vga_timing_gen #(
    .H_VISIBLE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
    .V_VISIBLE (12), .V_FP (3), .V_SYNC (2), .V_BP (3)
  ) u_small (
    .vga_clk      (clk),
    .reset        (rst_b),
    .DrawX        (x_b),
    .DrawY        (y_b),
    .blank        (blank_b),
    .hs           (hs_b),
    .vs           (vs_b),
    .frame_start  (fs_b),
    .vblank_start (vb_b),
    .frame_count  (fc_b)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    int   k;
    int   x;
    int   y;
    logic b;
    logic h;
    logic v;
    logic fs;
    logic vb;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int hs_low, hs_first, hs_last, blank_zero, vs_low_a, pulses_a;
    int fs_cnt, vb_cnt, vs_low, vs_ymin, vs_ymax;
    int fs_k[3];
    int prev_x, prev_y;
    int exp_fc;

    checks   = 0;
    failures = 0;
    cyc      = 0;

    // k = clocks since reset release; X advances one per clock on an 800-clock line.
    vecs[0]  = '{0,    0,   0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1,    1,   0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{639,  639, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{640,  640, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{655,  655, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{656,  656, 0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{751,  751, 0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{752,  752, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{799,  799, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{800,  0,   1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{8799, 799, 10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{8800, 0,   11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);

    check("rst.DrawX", x_a, 0);
    check("rst.DrawY", y_a, 0);
    check("rst.blank", blank_a, 0);
    check("rst.hs", hs_a, 1);
    check("rst.vs", vs_a, 1);
    check("rst.frame_start", fs_a, 0);
    check("rst.vblank_start", vb_a, 0);
    check("rst.frame_count", fc_a, 0);

    rst_a = 1'b0;
    cyc   = 0;

    for (int i = 0; i < 12; i++) begin
      while (cyc < vecs[i].k) step();
      check($sformatf("v%0d.DrawX", i), x_a, vecs[i].x);
      check($sformatf("v%0d.DrawY", i), y_a, vecs[i].y);
      check($sformatf("v%0d.blank", i), blank_a, vecs[i].b);
      check($sformatf("v%0d.hs", i), hs_a, vecs[i].h);
      check($sformatf("v%0d.vs", i), vs_a, vecs[i].v);
      check($sformatf("v%0d.frame_start", i), fs_a, vecs[i].fs);
      check($sformatf("v%0d.vblank_start", i), vb_a, vecs[i].vb);
    end

    // Scan line 11 of the full-size raster.
    hs_low = 0; hs_first = -1; hs_last = -1; blank_zero = 0; vs_low_a = 0; pulses_a = 0;
    for (int n = 0; n < 800; n++) begin
      if (hs_a == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(x_a);
        hs_last = int'(x_a);
      end
      if (blank_a == 1'b0) blank_zero++;
      if (vs_a == 1'b0) vs_low_a++;
      if (fs_a || vb_a) pulses_a++;
      step();
    end
    check("line.hs_low_clocks", hs_low, 96);
    check("line.hs_first_x", hs_first, 656);
    check("line.hs_last_x", hs_last, 751);
    check("line.blank_zero_clocks", blank_zero, 160);
    check("line.vs_low_clocks", vs_low_a, 0);
    check("line.strobes", pulses_a, 0);
    check("line.DrawY_after", y_a, 12);
    check("line.frame_count", fc_a, 0);

    // Small instance: three whole frames.
    rst_b = 1'b0;
    cyc   = 0;
    fs_cnt = 0; vb_cnt = 0; vs_low = 0; vs_ymin = 1000; vs_ymax = -1;
    fs_k[0] = -1; fs_k[1] = -1; fs_k[2] = -1;
    prev_x = -1; prev_y = -1;
    for (int k = 0; k <= 1920; k++) begin
      if (fs_b) begin
        if (fs_cnt < 3) fs_k[fs_cnt] = k;
        fs_cnt++;
        check("frame.fs_at_x0", x_b, 0);
        check("frame.fs_at_y0", y_b, 0);
        check("frame.fs_prev_x", prev_x, 31);
        check("frame.fs_prev_y", prev_y, 19);
      end
      if (vb_b) begin
        vb_cnt++;
        check("frame.vb_x", x_b, 0);
        check("frame.vb_y", y_b, 12);
      end
      if (k < 640 && vs_b == 1'b0) begin
        vs_low++;
        if (int'(y_b) < vs_ymin) vs_ymin = int'(y_b);
        if (int'(y_b) > vs_ymax) vs_ymax = int'(y_b);
      end
      prev_x = int'(x_b);
      prev_y = int'(y_b);
      if (k < 1920) step();
    end
    check("frame.fs_count", fs_cnt, 3);
    check("frame.first_fs_clock", fs_k[0], 640);
    check("frame.fs_interval", fs_k[1] - fs_k[0], 640);
    check("frame.vb_count", vb_cnt, 3);
    check("frame.vs_low_clocks", vs_low, 64);
    check("frame.vs_first_y", vs_ymin, 15);
    check("frame.vs_last_y", vs_ymax, 16);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    exp_fc = 3;
`else
    exp_fc = 0;
`endif
    check("frame.frame_count", fc_b, exp_fc);

    // Asynchronous reset mid-frame at (10,7).
    for (int n = 0; n < 234; n++) step();
    check("mid.DrawX_before", x_b, 10);
    check("mid.DrawY_before", y_b, 7);
    check("mid.blank_before", blank_b, 1);
    #5;
    rst_b = 1'b1;
    #1;
    check("async.DrawX", x_b, 0);
    check("async.DrawY", y_b, 0);
    check("async.blank", blank_b, 0);
    check("async.hs", hs_b, 1);
    check("async.vs", vs_b, 1);
    check("async.frame_start", fs_b, 0);
    check("async.vblank_start", vb_b, 0);
    check("async.frame_count", fc_b, 0);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    step();
    check("restart.DrawX", x_b, 1);
    check("restart.DrawY", y_b, 0);
    check("restart.blank", blank_b, 1);
    check("restart.frame_start", fs_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
